// File: rtl/mem_1rw_arb.sv
// Single-port byte-writable memory with a round-robin read/write arbiter,
// optional zero-fill sweep after reset and a 1- or 2-cycle read pipeline.
module mem_1rw_arb #(
  parameter int    WIDTH_DATA = 64,
  parameter int    WIDTH_ADDR = 8,
  parameter string DOUT_REG   = "false",
  parameter string INIT_ZERO  = "true"
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [WIDTH_ADDR-1:0]   wr_addr,
  input  logic [WIDTH_DATA-1:0]   wr_data,
  input  logic [WIDTH_DATA/8-1:0] wr_be,
  input  logic                    rd_valid,
  output logic                    rd_ready,
  input  logic [WIDTH_ADDR-1:0]   rd_addr,
  output logic                    rsp_valid,
  output logic [WIDTH_DATA-1:0]   rsp_data,
  output logic                    init_done
);

  localparam int NB    = WIDTH_DATA / 8;
  localparam int DEPTH = 2 ** WIDTH_ADDR;
  localparam bit DoutRegEn = (DOUT_REG == "true");
  localparam bit InitEn    = (INIT_ZERO == "true");

  typedef enum logic {ST_INIT, ST_IDLE} state_e;

  state_e                  state_q;
  logic                    init_done_q;
  logic [WIDTH_ADDR-1:0]   init_cnt_q;
  logic [WIDTH_ADDR-1:0]   init_cnt_d;
  logic                    wr_pri_q;
  logic                    wr_gnt;
  logic                    rd_gnt;
  logic                    init_we;
  logic                    rsp_valid_q;
  logic [WIDTH_DATA-1:0]   rsp_data_q;
  logic [WIDTH_DATA-1:0]   mem_q [DEPTH];

  // wr_pri_q=1 means write wins the next contended cycle
  assign wr_gnt = rst_n & init_done_q & wr_valid & (~rd_valid | wr_pri_q);
  assign rd_gnt = rst_n & init_done_q & rd_valid & (~wr_valid | ~wr_pri_q);

  assign wr_ready   = wr_gnt;
  assign rd_ready   = rd_gnt;
  assign init_done  = init_done_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign init_cnt_d = init_cnt_q + WIDTH_ADDR'(1);
  assign init_we    = rst_n & (state_q == ST_INIT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= InitEn ? ST_INIT : ST_IDLE;
      init_done_q <= 1'b0;
      init_cnt_q  <= '0;
      wr_pri_q    <= 1'b1;
    end else begin
      if (init_done_q && wr_valid && rd_valid) begin
        wr_pri_q <= rd_gnt;
      end
      case (state_q)
        ST_INIT: begin
          init_cnt_q <= init_cnt_d;
          // last address found by all-ones compare; counter wraps naturally
          if (&init_cnt_q) begin
            state_q     <= ST_IDLE;
            init_done_q <= 1'b1;
          end
        end
        ST_IDLE: init_done_q <= 1'b1;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (init_we) begin
      mem_q[init_cnt_q] <= '0;
    end else if (wr_gnt) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_be[b]) begin
          mem_q[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  generate
    if (DoutRegEn) begin : g_dout_reg
      logic [WIDTH_DATA-1:0] data_p1;
      logic                  vld_p1;

      // stage p1: array read
      always_ff @(posedge clk) begin
        if (rd_gnt) begin
          data_p1 <= mem_q[rd_addr];
        end
      end

      // stage p2: output register
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          vld_p1      <= 1'b0;
          rsp_valid_q <= 1'b0;
          rsp_data_q  <= '0;
        end else begin
          vld_p1      <= rd_gnt;
          rsp_valid_q <= vld_p1;
          if (vld_p1) begin
            rsp_data_q <= data_p1;
          end
        end
      end
    end else begin : g_dout_direct
      // stage p1: array read straight into the output register
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          rsp_valid_q <= 1'b0;
          rsp_data_q  <= '0;
        end else begin
          rsp_valid_q <= rd_gnt;
          if (rd_gnt) begin
            rsp_data_q <= mem_q[rd_addr];
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_mem_1rw_arb.sv
// Directed bench for mem_1rw_arb: three instances (1-cycle, 2-cycle, no-init)
// share stimulus; per-cycle expectations come from a hand-computed table.
module tb_mem_1rw_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_valid;
  logic [3:0]  wr_addr;
  logic [63:0] wr_data;
  logic [7:0]  wr_be;
  logic        rd_valid;
  logic [3:0]  rd_addr;

  logic        wr_ready0, rd_ready0, rsp_valid0, init_done0;
  logic        wr_ready1, rd_ready1, rsp_valid1, init_done1;
  logic        wr_ready2, rd_ready2, rsp_valid2, init_done2;
  logic [63:0] rsp_data0, rsp_data1, rsp_data2;

  int n_pass = 0;
  int n_total = 0;

  localparam logic [63:0] L25 = 64'hFFFF_FFFF_5566_7788;
  localparam logic [63:0] ALLF = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] DB = 64'hDEAD_BEEF_0000_1234;
  localparam int NV = 29;

  always #5 clk = ~clk;

  mem_1rw_arb #(.WIDTH_DATA(64), .WIDTH_ADDR(4), .DOUT_REG("false"), .INIT_ZERO("true")) dut0 (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready0), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_be(wr_be), .rd_valid(rd_valid), .rd_ready(rd_ready0), .rd_addr(rd_addr),
    .rsp_valid(rsp_valid0), .rsp_data(rsp_data0), .init_done(init_done0));

  mem_1rw_arb #(.WIDTH_DATA(64), .WIDTH_ADDR(4), .DOUT_REG("true"), .INIT_ZERO("true")) dut1 (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready1), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_be(wr_be), .rd_valid(rd_valid), .rd_ready(rd_ready1), .rd_addr(rd_addr),
    .rsp_valid(rsp_valid1), .rsp_data(rsp_data1), .init_done(init_done1));

  mem_1rw_arb #(.WIDTH_DATA(64), .WIDTH_ADDR(4), .DOUT_REG("false"), .INIT_ZERO("false")) dut2 (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready2), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_be(wr_be), .rd_valid(rd_valid), .rd_ready(rd_ready2), .rd_addr(rd_addr),
    .rsp_valid(rsp_valid2), .rsp_data(rsp_data2), .init_done(init_done2));

  typedef struct {
    logic        wv;
    logic [3:0]  wa;
    logic [63:0] wd;
    logic [7:0]  be;
    logic        rv;
    logic [3:0]  ra;
    logic        ewr;
    logic        err;
    logic        ev0;
    logic [63:0] ed0;
    logic        ev1;
    logic [63:0] ed1;
  } vec_t;

  vec_t vt [NV];

  function automatic vec_t mk(bit wv, int wa, logic [63:0] wd, logic [7:0] be, bit rv, int ra,
                              bit ewr, bit err, bit ev0, logic [63:0] ed0, bit ev1, logic [63:0] ed1);
    vec_t v;
    v.wv = wv; v.wa = 4'(wa); v.wd = wd; v.be = be; v.rv = rv; v.ra = 4'(ra);
    v.ewr = ewr; v.err = err; v.ev0 = ev0; v.ed0 = ed0; v.ev1 = ev1; v.ed1 = ed1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Waits for init_done on dut0 after reset release; returns cycles taken.
  task automatic wait_init(input string tag, output int n);
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) chk({tag, "_noinit_done"}, 64'(init_done2), 64'd1);
      if (init_done0) done = 1'b1;
      else begin
        chk({tag, "_init_wr_ready"}, 64'(wr_ready0), 64'd0);
        chk({tag, "_init_rd_ready"}, 64'(rd_ready1), 64'd0);
        chk({tag, "_init_rsp_valid1"}, 64'(rsp_valid1), 64'd0);
      end
    end
  endtask

  initial begin
    int n;
    //             wv wa wd                      be     rv ra ewr err ev0 ed0                     ev1 ed1
    vt[0]  = mk(1, 3, ALLF,                   8'hFF, 0, 0,  1, 0, 0, 64'h0,               0, 64'h0);
    vt[1]  = mk(1, 3, 64'h1122334455667788,   8'h0F, 0, 0,  1, 0, 0, 64'h0,               0, 64'h0);
    vt[2]  = mk(0, 0, 64'h0,                  8'h00, 1, 3,  0, 1, 1, L25,                 0, 64'h0);
    vt[3]  = mk(0, 0, 64'h0,                  8'h00, 0, 0,  0, 0, 0, L25,                 1, L25);
    vt[4]  = mk(1, 7, 64'hA5,                 8'hFF, 0, 0,  1, 0, 0, L25,                 0, L25);
    vt[5]  = mk(0, 0, 64'h0,                  8'h00, 1, 7,  0, 1, 1, 64'hA5,              0, L25);
    vt[6]  = mk(0, 0, 64'h0,                  8'h00, 1, 15, 0, 1, 1, 64'h0,               1, 64'hA5);
    vt[7]  = mk(0, 0, 64'h0,                  8'h00, 0, 0,  0, 0, 0, 64'h0,               1, 64'h0);
    vt[8]  = mk(0, 0, 64'h0,                  8'h00, 0, 0,  0, 0, 0, 64'h0,               0, 64'h0);
    vt[9]  = mk(1, 7, ALLF,                   8'h00, 0, 0,  1, 0, 0, 64'h0,               0, 64'h0);
    vt[10] = mk(0, 0, 64'h0,                  8'h00, 1, 7,  0, 1, 1, 64'hA5,              0, 64'h0);
    vt[11] = mk(0, 0, 64'h0,                  8'h00, 0, 0,  0, 0, 0, 64'hA5,              1, 64'hA5);
    vt[12] = mk(0, 0, 64'h0,                  8'h00, 0, 0,  0, 0, 0, 64'hA5,              0, 64'hA5);
    vt[13] = mk(1, 1, 64'h1111,               8'hFF, 1, 1,  1, 0, 0, 64'hA5,              0, 64'hA5);
    vt[14] = mk(1, 1, 64'h1111,               8'hFF, 1, 1,  0, 1, 1, 64'h1111,            0, 64'hA5);
    vt[15] = mk(1, 1, 64'h1111,               8'hFF, 1, 1,  1, 0, 0, 64'h1111,            1, 64'h1111);
    vt[16] = mk(1, 1, 64'h1111,               8'hFF, 1, 1,  0, 1, 1, 64'h1111,            0, 64'h1111);
    vt[17] = mk(1, 1, 64'h1111,               8'hFF, 1, 1,  1, 0, 0, 64'h1111,            1, 64'h1111);
    vt[18] = mk(1, 1, 64'h1111,               8'hFF, 1, 1,  0, 1, 1, 64'h1111,            0, 64'h1111);
    vt[19] = mk(0, 0, 64'h0,                  8'h00, 0, 0,  0, 0, 0, 64'h1111,            1, 64'h1111);
    vt[20] = mk(0, 0, 64'h0,                  8'h00, 0, 0,  0, 0, 0, 64'h1111,            0, 64'h1111);
    vt[21] = mk(1, 5, 64'h5555,               8'hFF, 0, 0,  1, 0, 0, 64'h1111,            0, 64'h1111);
    vt[22] = mk(1, 2, 64'h2222,               8'hFF, 1, 3,  1, 0, 0, 64'h1111,            0, 64'h1111);
    vt[23] = mk(1, 2, 64'h2222,               8'hFF, 1, 3,  0, 1, 1, L25,                 0, 64'h1111);
    vt[24] = mk(0, 0, 64'h0,                  8'h00, 0, 0,  0, 0, 0, L25,                 1, L25);
    vt[25] = mk(0, 0, 64'h0,                  8'h00, 1, 2,  0, 1, 1, 64'h2222,            0, L25);
    vt[26] = mk(0, 0, 64'h0,                  8'h00, 1, 5,  0, 1, 1, 64'h5555,            1, 64'h2222);
    vt[27] = mk(0, 0, 64'h0,                  8'h00, 0, 0,  0, 0, 0, 64'h5555,            1, 64'h5555);
    vt[28] = mk(0, 0, 64'h0,                  8'h00, 0, 0,  0, 0, 0, 64'h5555,            0, 64'h5555);

    rst_n = 1'b0; wr_valid = 1'b1; rd_valid = 1'b1;
    wr_addr = '0; wr_data = '0; wr_be = 8'hFF; rd_addr = '0;

    // Reset state, with both requests pending
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_valid0", 64'(rsp_valid0), 64'd0);
    chk("rst_rsp_data0", rsp_data0, 64'd0);
    chk("rst_rsp_valid1", 64'(rsp_valid1), 64'd0);
    chk("rst_rsp_data1", rsp_data1, 64'd0);
    chk("rst_rsp_valid2", 64'(rsp_valid2), 64'd0);
    chk("rst_rsp_data2", rsp_data2, 64'd0);
    chk("rst_init_done0", 64'(init_done0), 64'd0);
    chk("rst_init_done2", 64'(init_done2), 64'd0);
    chk("rst_wr_ready0", 64'(wr_ready0), 64'd0);
    chk("rst_rd_ready1", 64'(rd_ready1), 64'd0);
    chk("rst_wr_ready2", 64'(wr_ready2), 64'd0);
    chk("rst_rd_ready2", 64'(rd_ready2), 64'd0);

    // Init sweep length
    @(negedge clk);
    rst_n = 1'b1;
    wait_init("boot", n);
    chk("boot_init_cycles", 64'(n), 64'd16);
    chk("boot_init_done1", 64'(init_done1), 64'd1);

    // Table-driven traffic
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      wr_valid = vt[i].wv; wr_addr = vt[i].wa; wr_data = vt[i].wd; wr_be = vt[i].be;
      rd_valid = vt[i].rv; rd_addr = vt[i].ra;
      #1;
      chk($sformatf("v%0d_wr_ready0", i), 64'(wr_ready0), 64'(vt[i].ewr));
      chk($sformatf("v%0d_rd_ready0", i), 64'(rd_ready0), 64'(vt[i].err));
      chk($sformatf("v%0d_wr_ready1", i), 64'(wr_ready1), 64'(vt[i].ewr));
      chk($sformatf("v%0d_rd_ready1", i), 64'(rd_ready1), 64'(vt[i].err));
      @(posedge clk); #1;
      chk($sformatf("v%0d_rsp_valid0", i), 64'(rsp_valid0), 64'(vt[i].ev0));
      chk($sformatf("v%0d_rsp_data0", i), rsp_data0, vt[i].ed0);
      chk($sformatf("v%0d_rsp_valid1", i), 64'(rsp_valid1), 64'(vt[i].ev1));
      chk($sformatf("v%0d_rsp_data1", i), rsp_data1, vt[i].ed1);
    end

    // Mid-operation reset: read granted, then reset on the next edge
    @(negedge clk);
    wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 4'd3;
    @(posedge clk); #1;
    chk("mr_rsp_valid0", 64'(rsp_valid0), 64'd1);
    chk("mr_rsp_data0", rsp_data0, L25);
    @(negedge clk);
    rd_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mr_rst_rsp_valid1", 64'(rsp_valid1), 64'd0);
    chk("mr_rst_rsp_data1", rsp_data1, 64'd0);
    chk("mr_rst_init_done0", 64'(init_done0), 64'd0);
    chk("mr_rst_init_done1", 64'(init_done1), 64'd0);
    @(negedge clk);
    rst_n = 1'b1; wr_valid = 1'b1; rd_valid = 1'b1;
    wait_init("mr", n);
    chk("mr_init_cycles", 64'(n), 64'd16);
    chk("mr_rsp_valid1_after", 64'(rsp_valid1), 64'd0);

    // Array re-zeroed by the sweep; a fresh write is still visible
    @(negedge clk);
    wr_valid = 1'b1; rd_valid = 1'b0; wr_addr = 4'd4; wr_data = DB; wr_be = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 4'd4;
    @(posedge clk); #1;
    chk("post_rd4_valid0", 64'(rsp_valid0), 64'd1);
    chk("post_rd4_data0", rsp_data0, DB);
    @(negedge clk);
    rd_addr = 4'd3;
    @(posedge clk); #1;
    chk("post_rd3_data0", rsp_data0, 64'd0);
    chk("post_rd4_valid1", 64'(rsp_valid1), 64'd1);
    chk("post_rd4_data1", rsp_data1, DB);
    @(negedge clk);
    rd_valid = 1'b0;
    @(posedge clk); #1;
    chk("post_rd3_valid1", 64'(rsp_valid1), 64'd1);
    chk("post_rd3_data1", rsp_data1, 64'd0);
    chk("post_idle_valid0", 64'(rsp_valid0), 64'd0);
    @(posedge clk); #1;
    chk("post_idle_valid1", 64'(rsp_valid1), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
